ram_dma: RTL
============

# ram_dma

Block-copy engine that acts as the initiator on the single-port 4K×16 `ram` interface (`load`/`addr`/`d`/`q`). On a start pulse it reads `len` consecutive words from `src`, writes them to `dst` one word at a time, then pulses `done`. It sits between the tinycpu control logic and `ram` and owns that port while busy; external arbitration is out of scope.

## Interface
- `AW`, 12, RAM address width (4096 words).
- `DW`, 16, RAM data width.
- `RD_LAT`, 1, RAM read latency in cycles, range 0..3. 0 means `ram_q` is combinational from `ram_addr`; 1 means `ram_q` is valid in the cycle after the address is presented.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `start` input 1: command strobe, sampled only while `busy`=0.
- `src` input AW: first source address, captured on the start edge.
- `dst` input AW: first destination address, captured on the start edge.
- `len` input AW+1: word count, 0..4096, captured on the start edge.
- `busy` output 1: transfer in progress.
- `done` output 1: one-cycle completion pulse.
- `ram_load` output 1: RAM write enable, to `ram.load`.
- `ram_addr` output AW: to `ram.addr`.
- `ram_d` output DW: write data, to `ram.d`.
- `ram_q` input DW: read data, from `ram.q`.

## Operation
- Every output is registered.
- Reset values: `busy`=0, `done`=0, `ram_load`=0, `ram_addr`=0, `ram_d`=0. The state machine resets to IDLE and the counter to 0.
- State IDLE:
  - When `start`=1 and `len`≠0: latch `src`/`dst`/`len`, go to RD, set `busy`.
  - When `start`=1 and `len`=0: no RAM access. Pulse `done` in the next cycle and stay in IDLE.
- State RD: `ram_addr`=src+i, `ram_load`=0.
  - RD_LAT=0: capture `ram_q` into `ram_d` at the end of this cycle, then go to WR.
  - RD_LAT>0: go to WAIT.
- State WAIT: hold `ram_addr`. Stay RD_LAT cycles and capture `ram_q` on the last one, then go to WR.
- State WR: `ram_addr`=dst+i, `ram_load`=1, `ram_d`=captured word. Then i←i+1.
  - If i=len: go to IDLE, `busy`←0, `done`←1.
  - Otherwise: go to RD.
- Address arithmetic is modulo 2^AW. Addresses 0xFFF+1 wrap to 0x000 for both `src` and `dst`.
- Words are copied in ascending order. Overlapping regions with dst>src propagate already-copied data; this is the defined behaviour, not an error.
- `start` while `busy`=1 is ignored and not queued.
- A `start` in the same cycle that `done`=1 is accepted, because `busy` is already 0.
- `rst` mid-transfer drops `ram_load` immediately (asynchronously). The partial copy is left as is.

## Timing
- The start edge is E0.
- Copy mode: RD_LAT+2 cycles per word. `done` is high in the cycle following edge E0+len·(RD_LAT+2).
- `busy` is high from the cycle after E0 through the final WR cycle. It is low in the `done` cycle.
- `ram_load` is high for exactly one cycle per word and is never high outside WR.
- `len`=0: `done` is high in the cycle after E0 and `busy` never rises.

## Configuration
- Macro `RAM_DMA_FILL_EN`.
- Defined:
  - Adds input `mode` (1 bit) and input `fill_val` (DW), both captured on the start edge.
  - `mode`=1 skips RD/WAIT: each word is a single WR cycle writing `fill_val` to dst+i. `done` follows edge E0+len.
  - `mode`=0 is the copy mode described above.
- Undefined: the ports do not exist and only copy mode is built.

## Test plan
- Reset values: preload RAM 0x000..0x003 = 0x1111, 0x2222, 0x3333, 0x4444; RD_LAT=1; start src=0x000, dst=0x010, len=4 -> `done` at E0+12; RAM 0x010..0x013 match the source; exactly 4 `ram_load` pulses.
- Wrap-around: src=0xFFE, dst=0x7FF, len=3 with RAM[0xFFE,0xFFF,0x000] = 0xAAAA, 0xBBBB, 0xCCCC -> RAM[0x7FF,0x800,0x801] = 0xAAAA, 0xBBBB, 0xCCCC.
- `len`=0 -> `done` one cycle after start; `busy` stays 0; no `ram_load`.
- `start` re-pulsed mid-transfer with different `src` -> ignored; the original copy completes with unchanged timing. A second `start` in the `done` cycle -> accepted.
- `rst` asserted during the 2nd WR of len=4 -> `ram_load`=0 within the same cycle; all outputs at reset values; only word 0 (and word 1 if its write edge occurred) written.
- `RAM_DMA_FILL_EN`: `mode`=1, `fill_val`=0x0055, dst=0x010, len=2 -> RAM[0x010..0x011] = 0x0055; `done` at E0+2; no read cycles.

Source files
------------

// File: rtl/ram_dma_if.sv
// RAM-side bus of the block-copy engine: write enable, address, write data and read data.
interface ram_dma_if #(
    parameter int AW = 12,
    parameter int DW = 16
) ();
    logic          ram_load;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_d;
    logic [DW-1:0] ram_q;

    modport master (output ram_load, output ram_addr, output ram_d, input ram_q);
    modport slave  (input ram_load, input ram_addr, input ram_d, output ram_q);
endinterface

// File: rtl/ram_dma.sv
// Block-copy engine that owns a single-port RAM while busy: reads len words from src and writes them to dst.
// Defining RAM_DMA_FILL_EN adds mode/fill_val ports for a write-only constant-fill transfer.
module ram_dma #(
    parameter int AW     = 12,
    parameter int DW     = 16,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] src,
    input  logic [AW-1:0] dst,
    input  logic [AW:0]   len,
`ifdef RAM_DMA_FILL_EN
    input  logic          mode,
    input  logic [DW-1:0] fill_val,
`endif
    output logic          busy,
    output logic          done,
    ram_dma_if.master     ram
);
    typedef enum logic [1:0] {IDLE, RD, WAIT, WR} state_t;

    localparam logic [AW:0] ONE   = (AW+1)'(1);
    localparam logic [1:0]  WLAST = (RD_LAT > 0) ? 2'(RD_LAT - 1) : 2'd0;

    state_t        state, state_n;
    logic [AW:0]   idx, idx_n, idx_inc;
    logic [1:0]    wcnt, wcnt_n;
    logic          busy_n, done_n, load_n;
    logic [AW-1:0] addr_n;
    logic [DW-1:0] d_n;
    logic          capture, fill_go;
    logic [DW-1:0] fill_data;
    logic [AW-1:0] src_r, dst_r;
    logic [AW:0]   len_r;
    logic          fill_r;

`ifdef RAM_DMA_FILL_EN
    assign fill_go   = mode;
    assign fill_data = fill_val;
`else
    assign fill_go   = 1'b0;
    assign fill_data = '0;
`endif

    assign idx_inc = idx + ONE;

    // Command operands are only meaningful while busy, so they carry no reset.
    always_ff @(posedge clk) begin
        if (capture) begin
            src_r  <= src;
            dst_r  <= dst;
            len_r  <= len;
            fill_r <= fill_go;
        end
    end

    // Outputs are computed one cycle ahead so every port comes straight from a flop.
    always_comb begin
        state_n = state;
        idx_n   = idx;
        wcnt_n  = wcnt;
        busy_n  = busy;
        done_n  = 1'b0;
        load_n  = 1'b0;
        addr_n  = ram.ram_addr;
        d_n     = ram.ram_d;
        capture = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (len == '0) begin
                        done_n = 1'b1;
                    end else begin
                        capture = 1'b1;
                        busy_n  = 1'b1;
                        idx_n   = '0;
                        if (fill_go) begin
                            state_n = WR;
                            addr_n  = dst;
                            load_n  = 1'b1;
                            d_n     = fill_data;
                        end else begin
                            state_n = RD;
                            addr_n  = src;
                        end
                    end
                end
            end
            RD: begin
                if (RD_LAT == 0) begin
                    state_n = WR;
                    addr_n  = dst_r + idx[AW-1:0];
                    load_n  = 1'b1;
                    d_n     = ram.ram_q;
                end else begin
                    state_n = WAIT;
                    wcnt_n  = '0;
                end
            end
            WAIT: begin
                if (wcnt == WLAST) begin
                    state_n = WR;
                    addr_n  = dst_r + idx[AW-1:0];
                    load_n  = 1'b1;
                    d_n     = ram.ram_q;
                end else begin
                    wcnt_n = wcnt + 2'd1;
                end
            end
            WR: begin
                idx_n = idx_inc;
                if (idx_inc == len_r) begin
                    state_n = IDLE;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                end else if (fill_r) begin
                    addr_n = dst_r + idx_inc[AW-1:0];
                    load_n = 1'b1;
                end else begin
                    state_n = RD;
                    addr_n  = src_r + idx_inc[AW-1:0];
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            idx          <= '0;
            wcnt         <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            ram.ram_load <= 1'b0;
            ram.ram_addr <= '0;
            ram.ram_d    <= '0;
        end else begin
            state        <= state_n;
            idx          <= idx_n;
            wcnt         <= wcnt_n;
            busy         <= busy_n;
            done         <= done_n;
            ram.ram_load <= load_n;
            ram.ram_addr <= addr_n;
            ram.ram_d    <= d_n;
        end
    end
endmodule
